// File: rtl/seq_div_8by4.sv
// Iterative restoring unsigned divider, DW-bit dividend by VW-bit divisor,
// one quotient bit per cycle, valid/ready handshake on both sides.
module seq_div_8by4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dsr;
    logic [VW-1:0] pr;
    logic [VW:0]   pr_shift;
    logic [VW-1:0] pr_next;
    logic          q_bit;
    logic          accept;

    assign accept    = in_valid && (state == IDLE);
    assign remainder = pr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                if (count == '0) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial remainder is stored VW bits wide; the extra shifted-in bit only
    // guards the compare and is always cleared by a successful subtract.
    always_comb begin
        pr_shift = {pr, dvd[count]};
        q_bit    = 1'b0;
        pr_next  = pr_shift[VW-1:0];
        if (pr_shift >= {1'b0, dsr}) begin
            q_bit   = 1'b1;
            pr_next = VW'(pr_shift - {1'b0, dsr});
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            dvd         <= '0;
            dsr         <= '0;
            pr          <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd <= dividend;
            dsr <= divisor;
            if (divisor == '0) begin
                quotient    <= '1;
                pr          <= dividend[VW-1:0];
                div_by_zero <= 1'b1;
                count       <= '0;
            end else begin
                quotient    <= '0;
                pr          <= '0;
                div_by_zero <= 1'b0;
                count       <= CW'(DW - 1);
            end
        end else if (state == CALC) begin
            pr       <= pr_next;
            quotient <= {quotient[DW-2:0], q_bit};
            count    <= count - CW'(1);
        end
    end

endmodule
